// File: rtl/fnd_scan_controller.sv
// Digit-select scan generator for common-anode FNDs: prescaled slots, blank guard, mask, PWM.
// Latency: 1 cycle from i_blank/i_digit_mask to o_digit; no backpressure (free-running scan).
module fnd_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BRIGHT_W     = 4,
    localparam int IDX_W       = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_blank,
    input  logic [NUM_DIGITS-1:0] i_digit_mask,
    input  logic [BRIGHT_W-1:0]   i_brightness,
    output logic [NUM_DIGITS-1:0] o_digit,
    output logic [IDX_W-1:0]      o_digit_idx,
    output logic                  o_slot_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int WIN   = SCAN_DIV - BLANK_CYCLES;
    localparam int UNIT  = WIN / (1 << BRIGHT_W);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("fnd_scan_controller: NUM_DIGITS must be 2..8");
    end
    if (SCAN_DIV < 4) begin : g_bad_div
        $error("fnd_scan_controller: SCAN_DIV must be >= 4");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
        $error("fnd_scan_controller: BLANK_CYCLES must be < SCAN_DIV");
    end
    if (WIN < (1 << BRIGHT_W)) begin : g_bad_bright
        $error("fnd_scan_controller: SCAN_DIV-BLANK_CYCLES must be >= 2**BRIGHT_W");
    end

    typedef enum logic [1:0] {
        S_BLANK = 2'd0,
        S_ON    = 2'd1,
        S_OFF   = 2'd2
    } state_t;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BRIGHT_W-1:0]   bright_q, bright_d;
    state_t                state_q, state_d;
    logic [NUM_DIGITS-1:0] digit_q, digit_d;
    logic                  tick_q, tick_d;
    logic                  wrap;
    logic [31:0]           on_end;
    state_t                slot_start;

    always_comb begin
        wrap     = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        bright_d = bright_q;
        tick_d   = wrap;
        if (wrap) begin
            idx_d    = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            bright_d = i_brightness;
        end

        // Brightness only moves at the boundary, so on_end is constant within a slot.
        on_end     = 32'(BLANK_CYCLES) + (32'(bright_d) + 32'd1) * 32'(UNIT);
        slot_start = (BLANK_CYCLES == 0) ? S_ON : S_BLANK;

        state_d = state_q;
        case (state_q)
            S_BLANK: if (32'(cnt_d) >= 32'(BLANK_CYCLES)) state_d = S_ON;
            S_ON: begin
                if (wrap)                        state_d = slot_start;
                else if (32'(cnt_d) >= on_end)   state_d = S_OFF;
            end
            S_OFF:   if (wrap) state_d = slot_start;
            default: state_d = S_BLANK;
        endcase

        digit_d = '1;
        if (state_d == S_ON && !i_blank && i_digit_mask[idx_d]) begin
            digit_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            bright_q <= '0;
            state_q  <= S_BLANK;
            digit_q  <= '1;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            bright_q <= bright_d;
            state_q  <= state_d;
            digit_q  <= digit_d;
            tick_q   <= tick_d;
        end
    end

    assign o_digit     = digit_q;
    assign o_digit_idx = idx_q;
    assign o_slot_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: time-based reference model plus directed literal checks.
module tb_fnd_scan_controller;

    localparam int ND    = 4;
    localparam int DIV   = 20;
    localparam int BLK   = 4;
    localparam int BW    = 2;
    localparam int UNITC = (DIV - BLK) / (1 << BW);

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_blank = 1'b0;
    logic [ND-1:0] i_digit_mask = 4'b1111;
    logic [BW-1:0] i_brightness = 2'd3;
    logic [ND-1:0] o_digit;
    logic [1:0]    o_digit_idx;
    logic          o_slot_tick;

    fnd_scan_controller #(
        .NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK), .BRIGHT_W(BW)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_blank(i_blank),
        .i_digit_mask(i_digit_mask), .i_brightness(i_brightness),
        .o_digit(o_digit), .o_digit_idx(o_digit_idx), .o_slot_tick(o_slot_tick)
    );

    always #5 clk = ~clk;

    // Model: elapsed edges since reset, brightness of the current slot, sampled blank/mask.
    int          m_t = 0;
    int          m_bright = 0;
    logic        m_blank_s = 1'b0;
    logic [ND-1:0] m_mask_s = '1;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (i_reset) begin
            m_t      <= 0;
            m_bright <= 0;
            m_valid  <= 1'b1;
        end else begin
            m_t <= m_t + 1;
            if ((m_t + 1) % DIV == 0) m_bright <= int'(i_brightness);
        end
        m_blank_s <= i_blank;
        m_mask_s  <= i_digit_mask;
    end

    int   total = 0;
    int   bad = 0;
    logic prev_tick = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0d)", name, act, exp, m_t);
        end
    endtask

    task automatic compare_model();
        int cnt, idx, tick, dig;
        logic [ND-1:0] want;
        cnt  = m_t % DIV;
        idx  = (m_t / DIV) % ND;
        tick = (m_t > 0 && cnt == 0) ? 1 : 0;
        want = '1;
        if (cnt >= BLK && cnt < BLK + (m_bright + 1) * UNITC && !m_blank_s && m_mask_s[idx])
            want[idx] = 1'b0;
        dig = int'(want);
        chk("model_digit", int'(o_digit), dig);
        chk("model_idx", int'(o_digit_idx), idx);
        chk("model_tick", int'(o_slot_tick), tick);
        chk("one_low_max", ($countones(~o_digit) <= 1) ? 1 : 0, 1);
        chk("tick_not_back2back", (prev_tick && o_slot_tick) ? 1 : 0, 0);
        prev_tick = o_slot_tick;
    endtask

    task automatic step();
        @(negedge clk);
        if (m_valid) compare_model();
    endtask

    task automatic wait_t(input int k);
        int n;
        n = 0;
        while (m_t != k && n < 2000) begin
            step();
            n++;
        end
        if (m_t != k) begin
            chk("wait_timeout", m_t, k);
        end
    endtask

    task automatic lit(input string name, input int dig, input int idx, input int tick);
        chk({name, "_digit"}, int'(o_digit), dig);
        chk({name, "_idx"}, int'(o_digit_idx), idx);
        chk({name, "_tick"}, int'(o_slot_tick), tick);
    endtask

    initial begin
        step();
        step();
        lit("reset", 'hF, 0, 0);
        i_reset = 1'b0;

        // Slot 0 uses the reset brightness 0; later slots use 3.
        wait_t(3);   lit("s0_c3", 'hF, 0, 0);
        wait_t(4);   lit("s0_c4", 'hE, 0, 0);
        wait_t(7);   lit("s0_c7", 'hE, 0, 0);
        wait_t(8);   lit("s0_c8", 'hF, 0, 0);
        wait_t(20);  lit("s1_c0", 'hF, 1, 1);
        wait_t(21);  lit("s1_c1", 'hF, 1, 0);
        wait_t(24);  lit("s1_c4", 'hD, 1, 0);
        wait_t(39);  lit("s1_c19", 'hD, 1, 0);
        wait_t(44);  lit("s2_c4", 'hB, 2, 0);
        wait_t(64);  lit("s3_c4", 'h7, 3, 0);
        wait_t(80);  lit("s4_c0", 'hF, 0, 1);
        wait_t(84);  lit("s4_c4", 'hE, 0, 0);

        wait_t(85);  i_brightness = 2'd1;
        wait_t(104); lit("b1_c4", 'hD, 1, 0);
        wait_t(105); i_brightness = 2'd0;
        wait_t(111); lit("b1_c11", 'hD, 1, 0);
        wait_t(112); lit("b1_c12", 'hF, 1, 0);
        wait_t(124); lit("b0_c4", 'hB, 2, 0);
        wait_t(125); i_brightness = 2'd3;
        wait_t(127); lit("b0_c7", 'hB, 2, 0);
        wait_t(128); lit("b0_c8", 'hF, 2, 0);

        // Mid-slot brightness drop must wait for the next boundary.
        wait_t(190); i_brightness = 2'd0;
        wait_t(199); lit("late_c19", 'hD, 1, 0);
        wait_t(207); lit("drop_c7", 'hB, 2, 0);
        wait_t(208); lit("drop_c8", 'hF, 2, 0);

        wait_t(210); i_digit_mask = 4'b0101; i_brightness = 2'd3;
        wait_t(224); lit("mask_d3", 'hF, 3, 0);
        wait_t(244); lit("mask_d0", 'hE, 0, 0);
        wait_t(264); lit("mask_d1", 'hF, 1, 0);
        wait_t(284); lit("mask_d2", 'hB, 2, 0);
        wait_t(289); lit("preblank", 'hB, 2, 0); i_blank = 1'b1;
        wait_t(290); lit("blank_on", 'hF, 2, 0);
        wait_t(300); lit("blank_tick", 'hF, 3, 1);
        wait_t(324); lit("blank_c4", 'hF, 0, 0);
        wait_t(325); lit("blank_last", 'hF, 0, 0); i_blank = 1'b0;
        wait_t(326); lit("blank_off", 'hE, 0, 0);
        wait_t(330); i_digit_mask = 4'b1111;

        wait_t(372); lit("prerst", 'hB, 2, 0); i_reset = 1'b1;
        step();      lit("midrst", 'hF, 0, 0); i_reset = 1'b0;
        wait_t(4);   lit("rst_c4", 'hE, 0, 0);
        wait_t(8);   lit("rst_c8", 'hF, 0, 0);
        wait_t(20);  lit("rst_tick", 'hF, 1, 1);

        for (int i = 0; i < 10 * ND * DIV; i++) begin
            i_digit_mask = ND'($urandom_range(0, 15));
            i_blank      = ($urandom_range(0, 7) == 0);
            i_brightness = BW'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
